evg_event_arbiter: RTL and testbench

Merges the event-sequencer event stream with heartbeat and software event requests into the single event-code stream consumed by the EVG transmitter. Sits directly downstream of the event sequencer, in the transmitter clock domain. Sequencer events have no backpressure, so they are buffered in a FIFO. Codes drain into transmitter event slots under fixed priority.

---
 rtl/evg_event_arbiter_if.sv | 39 +++
 rtl/evg_event_arbiter.sv | 178 +++++++++++++++++
 tb/tb_evg_event_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/evg_event_arbiter_if.sv
// Event-stream bundle between the EVG sources, the arbiter and the transmitter.
// master drives requests and slots; slave is the arbiter.
interface evg_event_arbiter_if #(
  parameter int EVENTCODE_WIDTH = 8
);
  logic [EVENTCODE_WIDTH-1:0] evgSequenceEventTDATA;
  logic                       evgSequenceEventTVALID;
  logic [EVENTCODE_WIDTH-1:0] evgSwEventTDATA;
  logic                       evgSwEventTVALID;
  logic                       evgSwEventTREADY;
  logic                       evgHeartbeat;
  logic                       evgTxSlot;
  logic [EVENTCODE_WIDTH-1:0] evgTxEventCode;
  logic                       evgTxEventValid;

  modport master (
    output evgSequenceEventTDATA,
    output evgSequenceEventTVALID,
    output evgSwEventTDATA,
    output evgSwEventTVALID,
    input  evgSwEventTREADY,
    output evgHeartbeat,
    output evgTxSlot,
    input  evgTxEventCode,
    input  evgTxEventValid
  );

  modport slave (
    input  evgSequenceEventTDATA,
    input  evgSequenceEventTVALID,
    input  evgSwEventTDATA,
    input  evgSwEventTVALID,
    output evgSwEventTREADY,
    input  evgHeartbeat,
    input  evgTxSlot,
    output evgTxEventCode,
    output evgTxEventValid
  );
endinterface

// File: rtl/evg_event_arbiter.sv
// EVG event arbiter: heartbeat > sequencer FIFO > software, one code per slot.
// Define EVG_EVENT_ARBITER_STATS_EN to add the 16-bit status counters.
module evg_event_arbiter #(
  parameter int EVENTCODE_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_EVENT_CODE = 8'h7A,
  parameter logic [EVENTCODE_WIDTH-1:0] NULL_EVENT_CODE = 8'h00
) (
  input  logic evgTxClk,
  input  logic evgTxRst_n,
  evg_event_arbiter_if.slave bus,
  input  logic statsClear,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  output logic fifoOverflow
`ifdef EVG_EVENT_ARBITER_STATS_EN
  ,
  output logic [15:0] statusOverflowCount,
  output logic [15:0] statusHeartbeatLateCount,
  output logic [15:0] statusSwEventCount
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef logic [EVENTCODE_WIDTH-1:0] code_t;

  code_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            hb_pend_q, hb_pend_d;
  logic            ovf_q, ovf_d;
  code_t           code_q, code_d;
  logic            valid_q, valid_d;

  logic fifo_empty;
  logic fifo_full;
  logic grant_hb;
  logic pop;
  logic sw_rdy;
  logic sw_acc;
  logic push;
  logic drop;
  logic hb_late;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);

  assign grant_hb = bus.evgTxSlot & hb_pend_q;
  assign pop      = bus.evgTxSlot & ~hb_pend_q & ~fifo_empty;
  assign sw_rdy   = bus.evgTxSlot & ~hb_pend_q & fifo_empty;
  assign sw_acc   = sw_rdy & bus.evgSwEventTVALID;

  // A full FIFO still takes the write when the head leaves this cycle.
  assign push = bus.evgSequenceEventTVALID & (~fifo_full | pop);
  assign drop = bus.evgSequenceEventTVALID & fifo_full & ~pop;

  // A pulse that lands on the cycle its predecessor is granted is a new one.
  assign hb_late = bus.evgHeartbeat & hb_pend_q & ~grant_hb;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push & ~pop)
      level_d = level_q + LW'(1);
    else if (pop & ~push)
      level_d = level_q - LW'(1);
  end

  always_comb begin
    hb_pend_d = bus.evgHeartbeat | (hb_pend_q & ~grant_hb);
    ovf_d     = statsClear ? 1'b0 : (ovf_q | drop);
  end

  always_comb begin
    code_d  = NULL_EVENT_CODE;
    valid_d = 1'b0;
    unique case (1'b1)
      grant_hb: begin
        code_d  = HEARTBEAT_EVENT_CODE;
        valid_d = 1'b1;
      end
      pop: begin
        code_d  = mem_q[rd_ptr_q];
        valid_d = 1'b1;
      end
      sw_acc: begin
        code_d  = bus.evgSwEventTDATA;
        valid_d = 1'b1;
      end
      default: begin
        code_d  = NULL_EVENT_CODE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge evgTxClk) begin
    if (push) mem_q[wr_ptr_q] <= bus.evgSequenceEventTDATA;
  end

  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hb_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
      code_q    <= NULL_EVENT_CODE;
      valid_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      hb_pend_q <= hb_pend_d;
      ovf_q     <= ovf_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.evgSwEventTREADY = sw_rdy;
  assign bus.evgTxEventCode   = code_q;
  assign bus.evgTxEventValid  = valid_q;
  assign fifoLevel            = level_q;
  assign fifoOverflow         = ovf_q;

`ifdef EVG_EVENT_ARBITER_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0] late_cnt_q, late_cnt_d;
  logic [15:0] sw_cnt_q, sw_cnt_d;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  // Clear wins over any increment in the same cycle.
  always_comb begin
    ovf_cnt_d  = sat_inc(ovf_cnt_q, drop);
    late_cnt_d = sat_inc(late_cnt_q, hb_late);
    sw_cnt_d   = sat_inc(sw_cnt_q, sw_acc);
    if (statsClear) begin
      ovf_cnt_d  = '0;
      late_cnt_d = '0;
      sw_cnt_d   = '0;
    end
  end

  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      ovf_cnt_q  <= '0;
      late_cnt_q <= '0;
      sw_cnt_q   <= '0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      late_cnt_q <= late_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
    end
  end

  assign statusOverflowCount      = ovf_cnt_q;
  assign statusHeartbeatLateCount = late_cnt_q;
  assign statusSwEventCount       = sw_cnt_q;
`else
  logic unused_late;
  assign unused_late = hb_late;
`endif

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Directed bench for evg_event_arbiter.
// Counter checks are present when EVG_EVENT_ARBITER_STATS_EN is defined.
module tb_evg_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       statsClear = 1'b0;
  logic [4:0] fifoLevel;
  logic       fifoOverflow;
`ifdef EVG_EVENT_ARBITER_STATS_EN
  logic [15:0] ovc;
  logic [15:0] hlc;
  logic [15:0] swc;
`endif

  int errors = 0;
  int checks = 0;

  evg_event_arbiter_if #(.EVENTCODE_WIDTH(8)) bus ();

  evg_event_arbiter dut (
    .evgTxClk     (clk),
    .evgTxRst_n   (rst_n),
    .bus          (bus),
    .statsClear   (statsClear),
    .fifoLevel    (fifoLevel),
    .fifoOverflow (fifoOverflow)
`ifdef EVG_EVENT_ARBITER_STATS_EN
    ,
    .statusOverflowCount      (ovc),
    .statusHeartbeatLateCount (hlc),
    .statusSwEventCount       (swc)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic       v,
    input logic [7:0] c
  );
    chk({tag, ".valid"}, 32'(bus.evgTxEventValid), 32'(v));
    chk({tag, ".code"}, 32'(bus.evgTxEventCode), 32'(c));
  endtask

  initial begin
    bus.evgSequenceEventTDATA  = 8'h00;
    bus.evgSequenceEventTVALID = 1'b0;
    bus.evgSwEventTDATA        = 8'h00;
    bus.evgSwEventTVALID       = 1'b0;
    bus.evgHeartbeat           = 1'b0;
    bus.evgTxSlot              = 1'b0;

    // reset and idle slots
    tick;
    tick;
    chk_out("rst", 1'b0, 8'h00);
    chk("rst.level", 32'(fifoLevel), 32'd0);
    chk("rst.ovf", 32'(fifoOverflow), 32'd0);
    rst_n = 1'b1;
    bus.evgTxSlot = 1'b1;
    tick;
    tick;
    tick;
    chk_out("idle", 1'b0, 8'h00);
    chk("idle.level", 32'(fifoLevel), 32'd0);

    // three back-to-back sequencer codes
    bus.evgSequenceEventTVALID = 1'b1;
    bus.evgSequenceEventTDATA  = 8'h10;
    tick;
    chk("seq.lvl1", 32'(fifoLevel), 32'd1);
    chk_out("seq.n1", 1'b0, 8'h00);
    bus.evgSequenceEventTDATA = 8'h11;
    tick;
    chk_out("seq.10", 1'b1, 8'h10);
    chk("seq.lvl2", 32'(fifoLevel), 32'd1);
    bus.evgSequenceEventTDATA = 8'h12;
    tick;
    chk_out("seq.11", 1'b1, 8'h11);
    chk("seq.lvl3", 32'(fifoLevel), 32'd1);
    bus.evgSequenceEventTVALID = 1'b0;
    tick;
    chk_out("seq.12", 1'b1, 8'h12);
    chk("seq.lvl4", 32'(fifoLevel), 32'd0);
    tick;
    chk_out("seq.end", 1'b0, 8'h00);

    // overflow: 17 writes with no slots
    bus.evgTxSlot = 1'b0;
    bus.evgSequenceEventTVALID = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.evgSequenceEventTDATA = 8'(32'h20 + i);
      tick;
    end
    bus.evgSequenceEventTVALID = 1'b0;
    chk("ovf.level", 32'(fifoLevel), 32'd16);
    chk("ovf.flag", 32'(fifoOverflow), 32'd1);
    chk_out("ovf.noslot", 1'b0, 8'h00);
`ifdef EVG_EVENT_ARBITER_STATS_EN
    chk("ovf.count", 32'(ovc), 32'd1);
`endif
    bus.evgTxSlot = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk_out($sformatf("drain%0d", i), 1'b1, 8'(32'h20 + i));
      chk($sformatf("drain%0d.lvl", i), 32'(fifoLevel), 32'(15 - i));
    end
    tick;
    chk_out("drain.no30", 1'b0, 8'h00);
    chk("ovf.sticky", 32'(fifoOverflow), 32'd1);

    // stats clear
    bus.evgTxSlot = 1'b0;
    statsClear = 1'b1;
    tick;
    statsClear = 1'b0;
    chk("clr.flag", 32'(fifoOverflow), 32'd0);
`ifdef EVG_EVENT_ARBITER_STATS_EN
    chk("clr.count", 32'(ovc), 32'd0);
`endif

    // full with simultaneous pop: write accepted, level holds
    bus.evgSequenceEventTVALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.evgSequenceEventTDATA = 8'(32'h60 + i);
      tick;
    end
    chk("fp.full", 32'(fifoLevel), 32'd16);
    bus.evgTxSlot = 1'b1;
    bus.evgSequenceEventTDATA = 8'h70;
    tick;
    bus.evgSequenceEventTVALID = 1'b0;
    chk_out("fp.60", 1'b1, 8'h60);
    chk("fp.level", 32'(fifoLevel), 32'd16);
    chk("fp.noovf", 32'(fifoOverflow), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk_out($sformatf("fp%0d", i), 1'b1, 8'(32'h60 + i));
    end
    tick;
    chk_out("fp.end", 1'b0, 8'h00);
    chk("fp.empty", 32'(fifoLevel), 32'd0);

    // priority: heartbeat, sequencer, software in the same cycle
    bus.evgTxSlot = 1'b0;
    bus.evgHeartbeat = 1'b1;
    bus.evgSequenceEventTVALID = 1'b1;
    bus.evgSequenceEventTDATA = 8'h40;
    bus.evgSwEventTVALID = 1'b1;
    bus.evgSwEventTDATA = 8'h55;
    #1;
    chk("pri.rdy0", 32'(bus.evgSwEventTREADY), 32'd0);
    tick;
    bus.evgHeartbeat = 1'b0;
    bus.evgSequenceEventTVALID = 1'b0;
    bus.evgTxSlot = 1'b1;
    #1;
    chk("pri.rdy1", 32'(bus.evgSwEventTREADY), 32'd0);
    tick;
    chk_out("pri.7A", 1'b1, 8'h7A);
    chk("pri.rdy2", 32'(bus.evgSwEventTREADY), 32'd0);
    tick;
    chk_out("pri.40", 1'b1, 8'h40);
    chk("pri.rdy3", 32'(bus.evgSwEventTREADY), 32'd1);
    tick;
    bus.evgSwEventTVALID = 1'b0;
    chk_out("pri.55", 1'b1, 8'h55);
`ifdef EVG_EVENT_ARBITER_STATS_EN
    chk("pri.swcount", 32'(swc), 32'd1);
`endif
    tick;
    chk_out("pri.end", 1'b0, 8'h00);

    // late heartbeat merges into the pending one
    bus.evgTxSlot = 1'b0;
    bus.evgHeartbeat = 1'b1;
    tick;
    bus.evgHeartbeat = 1'b0;
    tick;
    tick;
    bus.evgHeartbeat = 1'b1;
    tick;
    bus.evgHeartbeat = 1'b0;
`ifdef EVG_EVENT_ARBITER_STATS_EN
    chk("late.count", 32'(hlc), 32'd1);
`endif
    bus.evgTxSlot = 1'b1;
    tick;
    chk_out("late.7A", 1'b1, 8'h7A);
    tick;
    chk_out("late.single", 1'b0, 8'h00);

    // asynchronous reset mid-operation
    bus.evgTxSlot = 1'b0;
    bus.evgSequenceEventTVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.evgSequenceEventTDATA = 8'(32'h80 + i);
      tick;
    end
    bus.evgSequenceEventTVALID = 1'b0;
    bus.evgTxSlot = 1'b1;
    bus.evgHeartbeat = 1'b1;
    tick;
    bus.evgHeartbeat = 1'b0;
    bus.evgTxSlot = 1'b0;
    chk_out("ar.pre", 1'b1, 8'h80);
    chk("ar.prelvl", 32'(fifoLevel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar.async", 1'b0, 8'h00);
    chk("ar.lvl", 32'(fifoLevel), 32'd0);
    tick;
    rst_n = 1'b1;
    bus.evgTxSlot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_out($sformatf("ar.post%0d", i), 1'b0, 8'h00);
    end
    chk("ar.postlvl", 32'(fifoLevel), 32'd0);
`ifdef EVG_EVENT_ARBITER_STATS_EN
    chk("ar.swc", 32'(swc), 32'd0);
    chk("ar.hlc", 32'(hlc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
